// File: rtl/video_sync_decoder.sv
// Receive-side sync decoder: recovers line/frame timing from h/v sync, locks onto a stable
// raster and emits (x,y)-addressed pixel samples inside the active window.
module video_sync_decoder #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned CNT_W        = 12,
    parameter int unsigned LINE_W       = 10,
    parameter int unsigned H_ACTIVE_OFS = 16,
    parameter int unsigned H_ACTIVE     = 320,
    parameter int unsigned V_ACTIVE_OFS = 8,
    parameter int unsigned V_ACTIVE     = 200,
    parameter int unsigned H_TOL        = 2,
    parameter int unsigned LOCK_FRAMES  = 2,
    parameter logic        SYNC_POL     = 1'b1
) (
    input  logic              setup_clk_i,
    input  logic              reset_ni,
    input  logic              cclk_en_i,
    input  logic              h_sync_i,
    input  logic              v_sync_i,
    input  logic              video_i,
    output logic              pixel_o,
    output logic              pixel_valid_o,
    output logic [CNT_W-1:0]  x_o,
    output logic [LINE_W-1:0] y_o,
    output logic              frame_start_o,
    output logic              locked_o,
    output logic [CNT_W-1:0]  h_period_o,
    output logic [LINE_W-1:0] v_lines_o,
    output logic [1:0]        dbg_state_o
);

    // pixel_valid_o qualifies pixel_o/x_o/y_o for exactly one clock; there is no ready,
    // the sink must take every strobe.
    typedef enum logic [1:0] {S_SEARCH = 2'd0, S_MEASURE = 2'd1, S_LOCKED = 2'd2} state_e;

    localparam int unsigned        MATCH_W    = $clog2(LOCK_FRAMES + 1);
    localparam logic [CNT_W-1:0]   H_LO       = CNT_W'(H_ACTIVE_OFS);
    localparam logic [CNT_W-1:0]   H_HI       = CNT_W'(H_ACTIVE_OFS + H_ACTIVE);
    localparam logic [LINE_W-1:0]  V_LO       = LINE_W'(V_ACTIVE_OFS);
    localparam logic [LINE_W-1:0]  V_HI       = LINE_W'(V_ACTIVE_OFS + V_ACTIVE);
    localparam logic [CNT_W-1:0]   TOL        = CNT_W'(H_TOL);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_FRAMES - 1);

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] hs_sync_q, hs_sync_d, vs_sync_q, vs_sync_d, vid_sync_q, vid_sync_d;
    logic                   hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic [CNT_W-1:0]       h_cnt_q, h_cnt_d, h_period_q, h_period_d, ref_period_q, ref_period_d;
    logic [LINE_W-1:0]      line_cnt_q, line_cnt_d, v_lines_q, v_lines_d, ref_lines_q, ref_lines_d;
    logic [MATCH_W-1:0]     match_q, match_d;
    logic                   pixel_q, pixel_d, pixel_valid_q, pixel_valid_d;
    logic [CNT_W-1:0]       x_q, x_d;
    logic [LINE_W-1:0]      y_q, y_d;
    logic                   frame_start_q, frame_start_d, locked_q, locked_d;

    logic                   hs_lvl, vs_lvl, h_edge, v_edge, h_sat, period_ok, in_window;
    logic [CNT_W-1:0]       new_period, period_diff;
    logic [LINE_W-1:0]      new_lines;

    always_comb begin
        hs_sync_d  = {hs_sync_q[SYNC_STAGES-2:0], h_sync_i};
        vs_sync_d  = {vs_sync_q[SYNC_STAGES-2:0], v_sync_i};
        vid_sync_d = {vid_sync_q[SYNC_STAGES-2:0], video_i};
        hs_lvl     = ~(hs_sync_q[SYNC_STAGES-1] ^ SYNC_POL);
        vs_lvl     = ~(vs_sync_q[SYNC_STAGES-1] ^ SYNC_POL);
        h_edge     = cclk_en_i & hs_lvl & ~hs_prev_q;
        v_edge     = cclk_en_i & vs_lvl & ~vs_prev_q;
        h_sat      = (h_cnt_q == '1);
        // A same-tick hsync counts its line before vsync closes the frame.
        new_period = h_edge ? h_cnt_q + CNT_W'(1) : h_period_q;
        new_lines  = (h_edge && line_cnt_q != '1) ? line_cnt_q + LINE_W'(1) : line_cnt_q;
        period_diff = (new_period >= ref_period_q) ? new_period - ref_period_q
                                                   : ref_period_q - new_period;
        period_ok  = (period_diff <= TOL);
        in_window  = (h_cnt_q >= H_LO) && (h_cnt_q < H_HI) &&
                     (line_cnt_q >= V_LO) && (line_cnt_q < V_HI);
    end

    always_comb begin
        hs_prev_d     = hs_prev_q;
        vs_prev_d     = vs_prev_q;
        h_cnt_d       = h_cnt_q;
        h_period_d    = h_period_q;
        line_cnt_d    = line_cnt_q;
        v_lines_d     = v_lines_q;
        x_d           = x_q;
        y_d           = y_q;
        pixel_d       = pixel_q;
        frame_start_d = v_edge;
        pixel_valid_d = cclk_en_i && (state_q == S_LOCKED) && in_window;
        if (cclk_en_i) begin
            hs_prev_d = hs_lvl;
            vs_prev_d = vs_lvl;
            if (h_edge) begin
                h_period_d = new_period;
                h_cnt_d    = '0;
            end else if (!h_sat) begin
                h_cnt_d = h_cnt_q + CNT_W'(1);
            end
            line_cnt_d = v_edge ? '0 : new_lines;
            if (v_edge) v_lines_d = new_lines;
        end
        if (pixel_valid_d) begin
            x_d     = h_cnt_q - H_LO;
            y_d     = line_cnt_q - V_LO;
            pixel_d = vid_sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        state_d      = state_q;
        ref_period_d = ref_period_q;
        ref_lines_d  = ref_lines_q;
        match_d      = match_q;
        // A missing hsync overrides everything: the raster is gone.
        if (h_sat) begin
            state_d = S_SEARCH;
        end else begin
            case (state_q)
                S_SEARCH: begin
                    if (v_edge) begin
                        state_d      = S_MEASURE;
                        ref_period_d = new_period;
                        ref_lines_d  = new_lines;
                        match_d      = '0;
                    end
                end
                S_MEASURE: begin
                    if (v_edge) begin
                        if (new_lines == ref_lines_q && period_ok) begin
                            match_d = match_q + MATCH_W'(1);
                            if (match_d == MATCH_LAST) state_d = S_LOCKED;
                        end else begin
                            ref_period_d = new_period;
                            ref_lines_d  = new_lines;
                            match_d      = '0;
                        end
                    end
                end
                S_LOCKED: begin
                    if ((h_edge && !period_ok) || (v_edge && new_lines != ref_lines_q))
                        state_d = S_SEARCH;
                end
                default: state_d = S_SEARCH;
            endcase
        end
        locked_d = (state_d == S_LOCKED);
    end

    always_ff @(posedge setup_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q       <= S_SEARCH;
            hs_sync_q     <= '0;
            vs_sync_q     <= '0;
            vid_sync_q    <= '0;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            h_cnt_q       <= '0;
            h_period_q    <= '0;
            ref_period_q  <= '0;
            line_cnt_q    <= '0;
            v_lines_q     <= '0;
            ref_lines_q   <= '0;
            match_q       <= '0;
            pixel_q       <= 1'b0;
            pixel_valid_q <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_sync_q     <= hs_sync_d;
            vs_sync_q     <= vs_sync_d;
            vid_sync_q    <= vid_sync_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            h_cnt_q       <= h_cnt_d;
            h_period_q    <= h_period_d;
            ref_period_q  <= ref_period_d;
            line_cnt_q    <= line_cnt_d;
            v_lines_q     <= v_lines_d;
            ref_lines_q   <= ref_lines_d;
            match_q       <= match_d;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
        end
    end

    assign pixel_o       = pixel_q;
    assign pixel_valid_o = pixel_valid_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign frame_start_o = frame_start_q;
    assign locked_o      = locked_q;
    assign h_period_o    = h_period_q;
    assign v_lines_o     = v_lines_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_video_sync_decoder.sv
// Bench for video_sync_decoder on a scaled-down raster (40 ticks x 16 lines, 16x8 window) so
// whole frames stay short; a frame-level reference model checks every clock.
module tb_video_sync_decoder;

    localparam int S     = 2;
    localparam int CW    = 8;
    localparam int LW    = 6;
    localparam int HOFS  = 4;
    localparam int HACT  = 16;
    localparam int VOFS  = 2;
    localparam int VACT  = 8;
    localparam int TOL   = 2;
    localparam int LOCKF = 2;
    localparam int HMAX  = (1 << CW) - 1;
    localparam int LMAX  = (1 << LW) - 1;
    localparam int LINES = 16;
    localparam int M_SEARCH = 0, M_MEASURE = 1, M_LOCKED = 2;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset_ni = 1'b0;
    logic          cclk_en_i = 1'b0, h_sync_i = 1'b0, v_sync_i = 1'b0, video_i = 1'b0;
    logic          pixel_o, pixel_valid_o, frame_start_o, locked_o;
    logic [CW-1:0] x_o, h_period_o;
    logic [LW-1:0] y_o, v_lines_o;
    logic [1:0]    dbg_state_o;

    always #5 clk = ~clk;

    video_sync_decoder #(
        .SYNC_STAGES(S), .CNT_W(CW), .LINE_W(LW), .H_ACTIVE_OFS(HOFS), .H_ACTIVE(HACT),
        .V_ACTIVE_OFS(VOFS), .V_ACTIVE(VACT), .H_TOL(TOL), .LOCK_FRAMES(LOCKF), .SYNC_POL(1'b1)
    ) dut (
        .setup_clk_i(clk), .reset_ni(reset_ni), .cclk_en_i(cclk_en_i),
        .h_sync_i(h_sync_i), .v_sync_i(v_sync_i), .video_i(video_i),
        .pixel_o(pixel_o), .pixel_valid_o(pixel_valid_o), .x_o(x_o), .y_o(y_o),
        .frame_start_o(frame_start_o), .locked_o(locked_o), .h_period_o(h_period_o),
        .v_lines_o(v_lines_o), .dbg_state_o(dbg_state_o)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0, n_errors = 0;
    int valid_cnt = 0, fs_cnt = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] act_vec();
        return 64'({pixel_valid_o, pixel_o, x_o, y_o, frame_start_o, locked_o, h_period_o, v_lines_o});
    endfunction

    // ---------------- reference model (frame-level, integer arithmetic) ----------------
    int hist_h[$], hist_v[$], hist_d[$];
    int m_prev_h, m_prev_v, m_hcnt, m_line, m_period, m_vlines;
    int m_mode, m_ref_p, m_ref_l, m_match;
    int e_valid, e_pix, e_x, e_y, e_fs;

    function automatic int sat_inc(input int v, input int lim);
        return (v >= lim) ? lim : v + 1;
    endfunction

    task automatic model_push();
        exp_q.push_back(64'({1'(e_valid), 1'(e_pix), CW'(e_x), LW'(e_y), 1'(e_fs),
                             1'(m_mode == M_LOCKED), CW'(m_period), LW'(m_vlines)}));
    endtask

    task automatic model_reset();
        hist_h = {}; hist_v = {}; hist_d = {};
        for (int i = 0; i < S; i++) begin
            hist_h.push_back(0); hist_v.push_back(0); hist_d.push_back(0);
        end
        m_prev_h = 0; m_prev_v = 0; m_hcnt = 0; m_line = 0; m_period = 0; m_vlines = 0;
        m_mode = M_SEARCH; m_ref_p = 0; m_ref_l = 0; m_match = 0;
        e_valid = 0; e_pix = 0; e_x = 0; e_y = 0; e_fs = 0;
        model_push();
    endtask

    task automatic model_step(input int h, input int v, input int d, input int en);
        int sh, sv, sd, he, ve, new_p, new_l, diff;
        sh = hist_h.pop_front(); hist_h.push_back(h);
        sv = hist_v.pop_front(); hist_v.push_back(v);
        sd = hist_d.pop_front(); hist_d.push_back(d);
        he = 0; ve = 0;
        if (en != 0) begin
            he = (sh == 1 && m_prev_h == 0) ? 1 : 0;
            ve = (sv == 1 && m_prev_v == 0) ? 1 : 0;
            m_prev_h = sh; m_prev_v = sv;
        end
        e_fs = ve;
        e_valid = 0;
        if (en != 0 && m_mode == M_LOCKED && m_hcnt >= HOFS && m_hcnt < HOFS + HACT &&
            m_line >= VOFS && m_line < VOFS + VACT) begin
            e_valid = 1; e_x = m_hcnt - HOFS; e_y = m_line - VOFS; e_pix = sd;
        end
        new_p = (he != 0) ? (m_hcnt + 1) % (HMAX + 1) : m_period;
        new_l = (he != 0) ? sat_inc(m_line, LMAX) : m_line;
        diff  = new_p - m_ref_p;
        if (diff < 0) diff = -diff;
        if (m_hcnt == HMAX) m_mode = M_SEARCH;
        else if (m_mode == M_SEARCH) begin
            if (ve != 0) begin m_mode = M_MEASURE; m_ref_p = new_p; m_ref_l = new_l; m_match = 0; end
        end else if (m_mode == M_MEASURE) begin
            if (ve != 0) begin
                if (new_l == m_ref_l && diff <= TOL) begin
                    m_match++;
                    if (m_match == LOCKF - 1) m_mode = M_LOCKED;
                end else begin
                    m_ref_p = new_p; m_ref_l = new_l; m_match = 0;
                end
            end
        end else if ((he != 0 && diff > TOL) || (ve != 0 && new_l != m_ref_l)) begin
            m_mode = M_SEARCH;
        end
        if (en != 0) begin
            if (he != 0) begin m_period = new_p; m_hcnt = 0; end
            else m_hcnt = sat_inc(m_hcnt, HMAX);
            m_line = (ve != 0) ? 0 : new_l;
            if (ve != 0) m_vlines = new_l;
        end
        model_push();
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic h, input logic v, input logic d, input logic en);
        h_sync_i = h; v_sync_i = v; video_i = d; cclk_en_i = en;
        @(posedge clk); #1;
        if (!reset_ni) model_reset();
        else model_step(int'(h), int'(v), int'(d), int'(en));
        check("cycle", act_vec(), exp_q.pop_front());
        if (pixel_valid_o) valid_cnt++;
        if (frame_start_o) fs_cnt++;
    endtask

    task automatic do_tick(input logic h, input logic v, input int div);
        logic d;
        d = 1'($urandom_range(0, 1));
        for (int c = 0; c < div; c++) step(h, v, d, c == div - 1);
    endtask

    task automatic gen_line(input int len, input int idx, input int voff, input int div);
        for (int t = 0; t < len; t++)
            do_tick(t < 4, (idx == 0 && t >= voff) || idx == 1 || (idx == 2 && t < voff), div);
    endtask

    task automatic run_frame(input int l, input int div, input int voff, input int jitter);
        int len;
        for (int li = 0; li < LINES; li++) begin
            len = l;
            if (jitter != 0 && li >= 2 && li <= 12) len = l - 1 + $urandom_range(0, 2);
            gen_line(len, li, voff, div);
        end
    endtask

    task automatic do_reset(input int n);
        reset_ni = 1'b0;
        for (int i = 0; i < n; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        reset_ni = 1'b1;
        fs_cnt = 0; valid_cnt = 0;
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        int line_ticks, en_div, voff, jitter;
        int exp_period, exp_lines, exp_locked, exp_valid, exp_starts;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int l, div, voff;
        logic h, v;
        vecs[0] = '{40, 1,  0, 0, 40, 16, 1, 128, 4};
        vecs[1] = '{40, 1, 10, 0, 40, 16, 1, 128, 4};
        vecs[2] = '{40, 4,  0, 0, 40, 16, 1, 128, 4};
        vecs[3] = '{40, 1, 10, 1, 40, 16, 1, 128, 4};
        vecs[4] = '{48, 2,  5, 0, 48, 16, 1, 128, 4};

        do_reset(12);
        check("reset_strobes", 64'(valid_cnt + fs_cnt), 64'd0);

        for (int i = 0; i < 5; i++) begin
            do_reset(3);
            for (int f = 0; f < 3; f++)
                run_frame(vecs[i].line_ticks, vecs[i].en_div, vecs[i].voff, vecs[i].jitter);
            valid_cnt = 0;
            run_frame(vecs[i].line_ticks, vecs[i].en_div, vecs[i].voff, vecs[i].jitter);
            check("vec_period", 64'(h_period_o), 64'(vecs[i].exp_period));
            check("vec_lines",  64'(v_lines_o),  64'(vecs[i].exp_lines));
            check("vec_locked", 64'(locked_o),   64'(vecs[i].exp_locked));
            check("vec_valid",  64'(valid_cnt),  64'(vecs[i].exp_valid));
            check("vec_starts", 64'(fs_cnt),     64'(vecs[i].exp_starts));
        end

        // One line stretched by 4 ticks breaks lock at the hsync ending it.
        do_reset(3);
        for (int f = 0; f < 3; f++) run_frame(40, 1, 10, 0);
        for (int li = 0; li < 6; li++) gen_line(li == 5 ? 44 : 40, li, 10, 1);
        check("long_before", 64'(locked_o), 64'd1);
        gen_line(40, 6, 10, 1);
        check("long_drop", 64'(locked_o), 64'd0);
        for (int li = 7; li < LINES; li++) gen_line(40, li, 10, 1);
        run_frame(40, 1, 10, 0);
        check("long_measure", 64'(locked_o), 64'd0);
        run_frame(40, 1, 10, 0);
        check("long_relock", 64'(locked_o), 64'd1);

        // hsync disappears: lock holds until the tick counter saturates.
        valid_cnt = 0;
        for (int t = 0; t < 200; t++) do_tick(1'b0, 1'b0, 1);
        check("nosync_hold", 64'(locked_o), 64'd1);
        for (int t = 0; t < 100; t++) do_tick(1'b0, 1'b0, 1);
        check("nosync_drop", 64'(locked_o), 64'd0);
        check("nosync_valid", 64'(valid_cnt), 64'd0);
        for (int f = 0; f < 3; f++) run_frame(40, 1, 10, 0);
        check("nosync_relock", 64'(locked_o), 64'd1);

        // Asynchronous reset in the middle of the active window.
        for (int li = 0; li < 5; li++) gen_line(40, li, 10, 1);
        for (int t = 0; t < 10; t++) do_tick(t < 4, 1'b0, 1);
        check("midreset_locked", 64'(locked_o), 64'd1);
        reset_ni = 1'b0;
        #1;
        check("midreset_async", act_vec(), 64'd0);
        valid_cnt = 0; fs_cnt = 0;
        for (int i = 0; i < 8; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        check("midreset_strobes", 64'(valid_cnt + fs_cnt), 64'd0);
        reset_ni = 1'b1;

        // Random rasters with random enable rate and vsync phase.
        for (int r = 0; r < 2; r++) begin
            l = $urandom_range(30, 50); div = $urandom_range(1, 2); voff = $urandom_range(0, l - 1);
            do_reset(2);
            for (int f = 0; f < 4; f++) run_frame(l, div, voff, 0);
            check("rand_locked", 64'(locked_o), 64'd1);
            check("rand_period", 64'(h_period_o), 64'(l));
            check("rand_lines", 64'(v_lines_o), 64'd16);
        end

        // Unstructured sync/enable noise, checked cycle by cycle against the model.
        h = 1'b0; v = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) h = ~h;
            if ($urandom_range(0, 63) == 0) v = ~v;
            step(h, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        end

        // ---------------- final report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
